// File: rtl/bfloat_minmax_tracker.sv
// Streaming bfloat16 frame reducer: per-frame max/min with first-occurrence
// indices, beat count and NaN/index-wrap flags over valid/ready handshakes.
module bfloat_minmax_tracker #(
  parameter int unsigned IDX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_max,
  output logic [15:0]        out_min,
  output logic [IDX_W-1:0]   out_max_idx,
  output logic [IDX_W-1:0]   out_min_idx,
  output logic [IDX_W:0]     out_count,
  output logic               out_nan_seen,
  output logic               out_all_nan,
  output logic               out_idx_wrap
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [15:0] QNAN  = 16'h7FC0;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t             state;
  logic [15:0]        acc_max, acc_min;
  logic [IDX_W-1:0]   acc_max_idx, acc_min_idx, beat_idx;
  logic [CNT_W-1:0]   acc_count;
  logic               acc_nan, acc_valid, acc_wrap;

  logic [15:0]        nxt_max, nxt_min;
  logic [IDX_W-1:0]   nxt_max_idx, nxt_min_idx, nxt_idx;
  logic [CNT_W-1:0]   nxt_count;
  logic               nxt_nan, nxt_valid, nxt_wrap;
  logic               beat_go;

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
  endfunction

  // Monotonic unsigned key for the signed-magnitude order; both zeros share one key.
  function automatic logic [15:0] ord_key(input logic [15:0] v);
    if (v[14:0] == 15'd0) return 16'h8000;
    else if (v[15])       return {1'b0, ~v[14:0]};
    else                  return {1'b1, v[14:0]};
  endfunction

  assign in_ready = (state == ACCUM);
  assign out_valid = (state == EMIT);
  assign beat_go  = in_valid && (state == ACCUM);

  // Fold the current beat into the running accumulators.
  always_comb begin
    nxt_max     = acc_max;
    nxt_min     = acc_min;
    nxt_max_idx = acc_max_idx;
    nxt_min_idx = acc_min_idx;
    nxt_nan     = acc_nan;
    nxt_valid   = acc_valid;
    nxt_idx     = beat_idx + IDX_W'(1);
    nxt_count   = (acc_count == {CNT_W{1'b1}}) ? acc_count : acc_count + CNT_W'(1);
    nxt_wrap    = acc_wrap | acc_count[IDX_W];
    if (is_nan(in_data)) begin
      nxt_nan = 1'b1;
    end else if (!acc_valid) begin
      nxt_valid   = 1'b1;
      nxt_max     = in_data;
      nxt_min     = in_data;
      nxt_max_idx = beat_idx;
      nxt_min_idx = beat_idx;
    end else begin
      if (ord_key(in_data) > ord_key(acc_max)) begin
        nxt_max     = in_data;
        nxt_max_idx = beat_idx;
      end
      if (ord_key(in_data) < ord_key(acc_min)) begin
        nxt_min     = in_data;
        nxt_min_idx = beat_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc_max      <= '0;
      acc_min      <= '0;
      acc_max_idx  <= '0;
      acc_min_idx  <= '0;
      beat_idx     <= '0;
      acc_count    <= '0;
      acc_nan      <= 1'b0;
      acc_valid    <= 1'b0;
      acc_wrap     <= 1'b0;
      out_max      <= '0;
      out_min      <= '0;
      out_max_idx  <= '0;
      out_min_idx  <= '0;
      out_count    <= '0;
      out_nan_seen <= 1'b0;
      out_all_nan  <= 1'b0;
      out_idx_wrap <= 1'b0;
    end else if (state == ACCUM) begin
      if (beat_go) begin
        acc_max     <= nxt_max;
        acc_min     <= nxt_min;
        acc_max_idx <= nxt_max_idx;
        acc_min_idx <= nxt_min_idx;
        beat_idx    <= nxt_idx;
        acc_count   <= nxt_count;
        acc_nan     <= nxt_nan;
        acc_valid   <= nxt_valid;
        acc_wrap    <= nxt_wrap;
        if (in_last) begin
          state        <= EMIT;
          out_max      <= nxt_valid ? nxt_max : QNAN;
          out_min      <= nxt_valid ? nxt_min : QNAN;
          out_max_idx  <= nxt_valid ? nxt_max_idx : '0;
          out_min_idx  <= nxt_valid ? nxt_min_idx : '0;
          out_count    <= nxt_count;
          out_nan_seen <= nxt_nan;
          out_all_nan  <= !nxt_valid;
          out_idx_wrap <= nxt_wrap;
        end
      end
    end else if (out_ready) begin
      // Result consumed: start a fresh frame, leave out_* data as-is.
      state       <= ACCUM;
      acc_max     <= '0;
      acc_min     <= '0;
      acc_max_idx <= '0;
      acc_min_idx <= '0;
      beat_idx    <= '0;
      acc_count   <= '0;
      acc_nan     <= 1'b0;
      acc_valid   <= 1'b0;
      acc_wrap    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfloat_minmax_tracker.sv
// Directed bench for bfloat_minmax_tracker: two instances (IDX_W=8 and IDX_W=2)
// driven with identical frames from a vector table plus hand-written corner sequences.
module tb_bfloat_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready;
  logic [15:0] in_data;

  logic        a_in_ready, a_out_valid, a_nan, a_alln, a_wrap;
  logic [15:0] a_max, a_min;
  logic [7:0]  a_max_idx, a_min_idx;
  logic [8:0]  a_count;

  logic        b_in_ready, b_out_valid, b_nan, b_alln, b_wrap;
  logic [15:0] b_max, b_min;
  logic [1:0]  b_max_idx, b_min_idx;
  logic [2:0]  b_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bfloat_minmax_tracker #(.IDX_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_max(a_max), .out_min(a_min), .out_max_idx(a_max_idx), .out_min_idx(a_min_idx),
    .out_count(a_count), .out_nan_seen(a_nan), .out_all_nan(a_alln), .out_idx_wrap(a_wrap)
  );

  bfloat_minmax_tracker #(.IDX_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_max(b_max), .out_min(b_min), .out_max_idx(b_max_idx), .out_min_idx(b_min_idx),
    .out_count(b_count), .out_nan_seen(b_nan), .out_all_nan(b_alln), .out_idx_wrap(b_wrap)
  );

  typedef struct {
    int          len;
    logic [15:0] d [8];
    logic [15:0] mx;
    logic [15:0] mn;
    int          mxi;
    int          mni;
    logic        nan;
    logic        alln;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // IDX_W=8 expectations come from the table; IDX_W=2 ones are reduced from them.
  task automatic check_result(input vec_t v);
    int bc;
    bc = (v.len > 7) ? 7 : v.len;
    chk("a_out_valid", 32'(a_out_valid), 32'd1);
    chk("a_in_ready",  32'(a_in_ready),  32'd0);
    chk("a_max",       32'(a_max),       32'(v.mx));
    chk("a_min",       32'(a_min),       32'(v.mn));
    chk("a_max_idx",   32'(a_max_idx),   32'(v.mxi));
    chk("a_min_idx",   32'(a_min_idx),   32'(v.mni));
    chk("a_count",     32'(a_count),     32'(v.len));
    chk("a_nan",       32'(a_nan),       32'(v.nan));
    chk("a_all_nan",   32'(a_alln),      32'(v.alln));
    chk("a_wrap",      32'(a_wrap),      32'(v.len > 256));
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_max",       32'(b_max),       32'(v.mx));
    chk("b_min",       32'(b_min),       32'(v.mn));
    chk("b_max_idx",   32'(b_max_idx),   32'(v.mxi % 4));
    chk("b_min_idx",   32'(b_min_idx),   32'(v.mni % 4));
    chk("b_count",     32'(b_count),     32'(bc));
    chk("b_nan",       32'(b_nan),       32'(v.nan));
    chk("b_all_nan",   32'(b_alln),      32'(v.alln));
    chk("b_wrap",      32'(b_wrap),      32'(v.len > 4));
  endtask

  // Drive one beat per cycle; returns at edge+1 after the last beat.
  task automatic send_frame(input vec_t v);
    int n;
    for (int i = 0; i < v.len; i++) begin
      in_valid = 1'b1;
      in_data  = v.d[i];
      in_last  = (i == v.len - 1);
      n = 0;
      while (!a_in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
      else if (i > 0) chk("in_ready_mid_frame", 32'(n), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{4, '{16'h3F80, 16'h4000, 16'hBF80, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0},
                16'h4000, 16'hBF80, 1, 2, 1'b0, 1'b0};
    vecs[1] = '{2, '{16'h8000, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                16'h8000, 16'h8000, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{4, '{16'h7FC1, 16'hFF80, 16'h7F80, 16'h7FC0, 16'h0, 16'h0, 16'h0, 16'h0},
                16'h7F80, 16'hFF80, 2, 1, 1'b1, 1'b0};
    vecs[3] = '{6, '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h0, 16'h0},
                16'h40C0, 16'h3F80, 5, 0, 1'b0, 1'b0};
    vecs[4] = '{1, '{16'hBF80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                16'hBF80, 16'hBF80, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{4, '{16'h8001, 16'h0001, 16'h8005, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0},
                16'h0001, 16'h8005, 1, 2, 1'b0, 1'b0};
    vecs[6] = '{8, '{16'h4000, 16'h3F80, 16'h4000, 16'h3F80, 16'hFF81, 16'h3F80, 16'h4000, 16'h3F80},
                16'h4000, 16'h3F80, 0, 1, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_max",       32'(a_max),       32'd0);
    chk("rst_count",     32'(a_count),     32'd0);
    rst_n = 1'b1;

    // Garbage on in_data/in_last without in_valid must be ignored.
    in_data = 16'h4F00; in_last = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_no_valid", 32'(a_out_valid), 32'd0);
    end
    in_last = 1'b0;

    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k]);
      check_result(vecs[k]);
      @(posedge clk); #1;
      chk("post_out_valid", 32'(a_out_valid), 32'd0);
      chk("post_in_ready",  32'(a_in_ready),  32'd1);
    end

    // All-NaN frame with consumer back-pressure.
    v = '{1, '{16'h7FC1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
          16'h7FC0, 16'h7FC0, 0, 0, 1'b1, 1'b1};
    out_ready = 1'b0;
    send_frame(v);
    repeat (5) begin
      check_result(v);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check_result(v);
    @(posedge clk); #1;
    chk("nan_release_valid", 32'(a_out_valid), 32'd0);
    chk("nan_release_ready", 32'(a_in_ready),  32'd1);

    // Reset mid-frame discards the partial frame.
    in_valid = 1'b1; in_data = 16'h4100; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_count", 32'(a_count), 32'd0);
    chk("midrst_valid", 32'(a_out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 32'(a_out_valid), 32'd0);
    end
    v = '{1, '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
          16'h4000, 16'h4000, 0, 0, 1'b0, 1'b0};
    send_frame(v);
    check_result(v);
    @(posedge clk); #1;
    chk("final_ready", 32'(a_in_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
